// File: rtl/regfile_scoreboard.sv
// Dual-write register file with combinational bypass reads and a per-register
// busy scoreboard that tracks destinations reserved by issue and pending writeback.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  output logic [AW:0]      busy_cnt
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] wb_vec;
  logic [DEPTH-1:0] set_vec;
  logic             w0_en;
  logic             w1_en;
  logic             iss_acc;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{AW{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Port 1 is suppressed on an address collision so port 0 wins both the
  // array update and the bypass path.
  always_comb begin
    w0_en = we0 && !(ZR && (wa0 == '0));
    w1_en = we1 && !(ZR && (wa1 == '0)) && !(we0 && (wa0 == wa1));
  end

  always_comb begin
    wb_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wb_vec[i] = (we0 && (wa0 == AW'(i))) || (we1 && (wa1 == AW'(i)));
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ZR && (ra1 == '0))          rd1 = '0;
    else if (w0_en && (wa0 == ra1)) rd1 = wd0;
    else if (w1_en && (wa1 == ra1)) rd1 = wd1;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ZR && (ra2 == '0))          rd2 = '0;
    else if (w0_en && (wa0 == ra2)) rd2 = wd0;
    else if (w1_en && (wa1 == ra2)) rd2 = wd1;
  end

  // A same-cycle writeback frees the register, matching what the bypass shows.
  always_comb begin
    busy1     = busy[ra1] && !wb_vec[ra1];
    busy2     = busy[ra2] && !wb_vec[ra2];
    iss_ready = !busy[iss_rd] || wb_vec[iss_rd] || (ZR && (iss_rd == '0));
    iss_acc   = iss_valid && iss_ready;
  end

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      set_vec[i] = iss_acc && (iss_rd == AW'(i));
    end
    if (ZR) set_vec[0] = 1'b0;
  end

  // Set has priority over clear when issue and writeback hit the same entry.
  always_comb begin
    busy_nxt = (busy & ~wb_vec) | set_vec;
    if (ZR) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (w1_en) regs[wa1] <= wd1;
      if (w0_en) regs[wa0] <= wd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expectations are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_regfile_scoreboard;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             we0, we1;
  logic [AW-1:0]    wa0, wa1;
  logic [WIDTH-1:0] wd0, wd1;
  logic [AW-1:0]    ra1, ra2;
  logic [WIDTH-1:0] rd1, rd2;
  logic             busy1, busy2;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             iss_ready;
  logic [AW:0]      busy_cnt;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .busy_cnt(busy_cnt)
  );

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    iss_valid = 0; iss_rd = '0;
  endtask

  initial begin
    rst = 1; ra1 = '0; ra2 = '0;
    idle();
    tick(); tick();
    rst = 0;
    ra1 = 5; ra2 = 7; iss_rd = 3;
    push(0); push(0); push(0); push(0); push(1); push(0);
    settle();
    chk("post_reset_rd1", rd1);
    chk("post_reset_rd2", rd2);
    chk("post_reset_busy1", busy1);
    chk("post_reset_busy2", busy2);
    chk("post_reset_iss_ready", iss_ready);
    chk("post_reset_busy_cnt", busy_cnt);

    // dual write to 5: port 0 wins
    we0 = 1; wa0 = 5; wd0 = 32'hAAAA_0000;
    we1 = 1; wa1 = 5; wd1 = 32'h0000_1234;
    push(32'hAAAA_0000);
    settle();
    chk("dual_bypass_rd1", rd1);
    tick(); idle();
    push(32'hAAAA_0000);
    settle();
    chk("dual_array_rd1", rd1);

    // port 1 bypass then array read
    we1 = 1; wa1 = 7; wd1 = 32'hDEAD_BEEF;
    push(32'hDEAD_BEEF);
    settle();
    chk("bypass_rd2_same_cycle", rd2);
    tick(); idle();
    push(32'hDEAD_BEEF);
    settle();
    chk("bypass_rd2_after_edge", rd2);

    // zero register
    ra1 = 0;
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF;
    push(0);
    settle();
    chk("zero_bypass_rd1", rd1);
    tick(); idle();
    iss_valid = 1; iss_rd = 0;
    push(0); push(1);
    settle();
    chk("zero_array_rd1", rd1);
    chk("zero_iss_ready", iss_ready);
    tick(); idle();
    push(0); push(0);
    settle();
    chk("zero_busy_cnt", busy_cnt);
    chk("zero_rd1_after_issue", rd1);

    // scoreboard: issue 3 twice, then write back
    ra1 = 3;
    iss_valid = 1; iss_rd = 3;
    push(1);
    settle();
    chk("sb_first_iss_ready", iss_ready);
    tick();
    push(0); push(1); push(1);
    settle();
    chk("sb_second_iss_ready", iss_ready);
    chk("sb_busy_cnt_1", busy_cnt);
    chk("sb_busy1_set", busy1);
    tick(); idle();
    we0 = 1; wa0 = 3; wd0 = 32'h33;
    push(0); push(32'h33); push(1);
    settle();
    chk("sb_busy1_wb_same_cycle", busy1);
    chk("sb_rd1_wb_bypass", rd1);
    chk("sb_busy_cnt_before_clear", busy_cnt);
    tick(); idle();
    push(0); push(0);
    settle();
    chk("sb_busy_cnt_cleared", busy_cnt);
    chk("sb_busy1_cleared", busy1);

    // simultaneous set and clear on 9
    ra2 = 9;
    iss_valid = 1; iss_rd = 9;
    tick(); idle();
    push(1);
    settle();
    chk("sc_busy_cnt_pre", busy_cnt);
    iss_valid = 1; iss_rd = 9;
    we1 = 1; wa1 = 9; wd1 = 32'h99;
    push(1);
    settle();
    chk("sc_iss_ready_wb", iss_ready);
    tick(); idle();
    push(1); push(1); push(32'h99);
    settle();
    chk("sc_busy_cnt_post", busy_cnt);
    chk("sc_busy2_kept", busy2);
    chk("sc_rd2", rd2);
    we0 = 1; wa0 = 9; wd0 = 32'h9A;
    tick(); idle();
    push(0);
    settle();
    chk("sc_busy_cnt_release", busy_cnt);

    // registers 1..4 written and busy, then reset mid-operation
    for (int k = 1; k <= 4; k++) begin
      we0 = 1; wa0 = AW'(k); wd0 = 32'h11 * k;
      iss_valid = 1; iss_rd = AW'(k);
      tick();
    end
    idle();
    ra1 = 2; ra2 = 4; iss_rd = 6;
    push(4); push(32'h22); push(32'h44); push(1);
    settle();
    chk("rm_busy_cnt_4", busy_cnt);
    chk("rm_rd1_reg2", rd1);
    chk("rm_rd2_reg4", rd2);
    chk("rm_busy1_reg2", busy1);
    rst = 1;
    we0 = 1; wa0 = 2; wd0 = 32'h5555;
    iss_valid = 1; iss_rd = 6;
    push(32'h5555); push(32'h44);
    settle();
    chk("rm_rst_bypass_rd1", rd1);
    chk("rm_rst_array_rd2", rd2);
    tick();
    rst = 0; idle(); iss_rd = 6;
    push(0); push(0); push(0); push(1); push(0); push(0);
    settle();
    chk("rm_after_rd1", rd1);
    chk("rm_after_rd2", rd2);
    chk("rm_after_busy_cnt", busy_cnt);
    chk("rm_after_iss_ready", iss_ready);
    chk("rm_after_busy1", busy1);
    chk("rm_after_busy2", busy2);
    iss_rd = 3;
    push(1);
    settle();
    chk("rm_after_iss_ready_r3", iss_ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter DEPTH, default 32, register count; power of two, at least 4; AW = log2(DEPTH).
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports we0 in 1, wa0 in AW, wd0 in WIDTH: write port 0, higher priority.
REQ-007 SHALL have ports we1 in 1, wa1 in AW, wd1 in WIDTH: write port 1, lower priority.
REQ-008 SHALL have ports ra1, ra2  in  AW: read addresses.
REQ-009 SHALL have ports rd1, rd2  out  WIDTH: read data.
REQ-010 SHALL have ports busy1, busy2  out  1: a write to ra1 or ra2 is still pending.
REQ-011 SHALL have ports iss_valid in 1 and iss_rd in AW: issue request that reserves a destination register.
REQ-012 SHALL have port iss_ready  out  1: the issue request is accepted this cycle.
REQ-013 SHALL have port busy_cnt  out  AW+1: registered count of set busy bits.

Function
REQ-014 SHALL write the register array on the clock edge for each port whose weN is 1.
REQ-015 SHALL let port 0 win when wa0 equals wa1 with both enables high; the port 1 data is dropped.
REQ-016 SHALL, when ZERO_REG=1, ignore writes to address 0, read it as 0, and never mark it busy.
REQ-017 SHALL make reads combinational with write-through bypass, in priority order: port 0 match, then port 1 match, then array contents.
REQ-018 SHALL hold one busy bit per register; an issue is accepted when iss_valid and iss_ready are both 1.
REQ-019 SHALL set the busy bit of iss_rd on an accepted issue.
REQ-020 SHALL clear the busy bit of any address written by we0 or we1.
REQ-021 SHALL let the set win when an issue and a writeback target the same address in one cycle; the bit stays 1.
REQ-022 SHALL drive iss_ready = NOT busy[iss_rd], OR a writeback to iss_rd in the same cycle, OR (ZERO_REG=1 and iss_rd=0).
REQ-023 SHALL drive busyN = busy[raN] AND NOT (a writeback to raN in the same cycle); this keeps busy consistent with the bypass.
REQ-024 SHALL update busy_cnt each cycle to the population count of the next-state busy vector; it never wraps, since the maximum is DEPTH.
REQ-025 SHALL have no internal pipeline latency: write-to-read is visible in the same cycle via bypass and from the array in the next cycle.
REQ-026 SHALL raise no error when a write targets a non-busy register; the write completes normally.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, clear all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-028 SHALL let rst override same-cycle writes and issues; those writes and issues are discarded.
REQ-029 SHALL, during rst, keep the read outputs combinational: bypass still applies, and the array reads the pre-reset contents until the edge.
REQ-030 SHALL, on the first cycle after rst drops, read every register as 0 with busy1 = busy2 = 0 and iss_ready = 1.

Verification
REQ-031 SHALL cover dual write: we0 and we1 both to 5, wd0=0xAAAA0000, wd1=0x1234 -> next cycle, ra1=5 reads 0xAAAA0000.
REQ-032 SHALL cover bypass: we1 to 7 with 0xDEADBEEF, ra2=7 in the same cycle -> rd2=0xDEADBEEF before the edge, and rd2 holds that value after the edge.
REQ-033 SHALL cover the zero register: write 0xFFFFFFFF to 0, then issue iss_rd=0 -> rd1 stays 0, iss_ready=1, busy_cnt unchanged.
REQ-034 SHALL cover scoreboard: issue 3, then issue 3 again next cycle -> iss_ready=0 and busy_cnt=1; then we0 to 3 -> busy clears and busy_cnt=0 the following cycle.
REQ-035 SHALL cover simultaneous set and clear: busy[9]=1, then issue 9 together with writeback to 9 -> busy[9] stays 1 and busy_cnt is unchanged.
REQ-036 SHALL cover reset mid-operation: registers 1..4 written and busy, then rst=1 with we0 to 2 in the same cycle -> afterwards all reads are 0, busy_cnt=0, iss_ready=1.
